// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port instruction/data RAM between the CPU controller and a
// DMA/loader requester. The CPU has static priority. Its commands pass straight
// through to the RAM whenever the arbiter is idle. The DMA port is granted idle
// memory cycles only. Once granted, a DMA access always runs to completion, and
// the CPU is stalled until the arbiter is idle again.
//
// Optional build macro:
//   MEM_ARB_STARVE_GUARD_EN - adds a saturating starvation counter. After
//   STARVE_MAX IDLE cycles in which a pending DMA request lost to CPU traffic,
//   the DMA is granted and the CPU is stalled for that cycle. Without the
//   macro, continuous CPU traffic can starve the DMA indefinitely.
//
// Parameters:
//   AW         memory address width
//   DW         memory data width
//   STARVE_MAX DMA losing cycles before a forced grant (guard build only)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   cpu_cmd    CPU command: 10 READ, 01 WRITE, 00/11 none
//   cpu_addr   CPU address
//   cpu_wdata  CPU write data
//   cpu_stall  CPU command not forwarded this cycle; controller holds state
//   dma_req    DMA request, held until dma_ack
//   dma_we     DMA direction: 1 write, 0 read; stable while dma_req=1
//   dma_addr   DMA address; stable while dma_req=1
//   dma_wdata  DMA write data; stable while dma_req=1
//   dma_ack    one-cycle completion pulse (registered)
//   dma_rdata  registered DMA read data, valid with dma_ack after a read
//   mem_cmd    RAM command: 10 READ, 01 WRITE, 00 idle
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid the cycle after a READ is presented
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    cpu_cmd,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        DMA_RD,
        DMA_RD_DONE,
        DMA_WR
    } state_t;

    state_t state;

    logic cpu_active;
    logic dma_sample;
    logic force_grant;
    logic dma_grant;

    // 11 is treated as "no command", like 00.
    assign cpu_active = (cpu_cmd == CMD_READ) || (cpu_cmd == CMD_WRITE);

    // In the ack cycle the requester may still be holding the request it is
    // being acknowledged for. Ignoring dma_req there prevents a duplicate
    // transfer and leaves one IDLE cycle between back-to-back DMA accesses.
    assign dma_sample = dma_req && !dma_ack;

`ifdef MEM_ARB_STARVE_GUARD_EN
    // The +2 keeps the width non-zero even when STARVE_MAX is 0.
    localparam int CW = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    assign force_grant = (state == IDLE) && dma_sample && (starve_cnt == STARVE_LIMIT);
`else
    assign force_grant = 1'b0;
`endif

    // The DMA gets the RAM on an idle CPU cycle, or when the starvation guard
    // fires.
    assign dma_grant = (state == IDLE) && dma_sample && (!cpu_active || force_grant);

    // RAM-side mux. In IDLE the CPU path is combinational, so a CPU access
    // costs no extra cycle. Mid-DMA the RAM sees the DMA request and the CPU
    // is stalled. A forced grant also stalls the CPU in its IDLE cycle.
    always_comb begin
        mem_cmd   = CMD_NONE;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        case (state)
            IDLE: begin
                if (force_grant) begin
                    cpu_stall = cpu_active;
                end else if (cpu_active) begin
                    mem_cmd = cpu_cmd;
                end
            end
            DMA_RD, DMA_RD_DONE: begin
                mem_cmd   = CMD_READ;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                cpu_stall = cpu_active;
            end
            DMA_WR: begin
                mem_cmd   = CMD_WRITE;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                cpu_stall = cpu_active;
            end
            default: begin
                mem_cmd   = CMD_NONE;
                cpu_stall = 1'b0;
            end
        endcase
    end

    // Arbiter FSM with registered handshake outputs.
    // DMA_RD presents the address. DMA_RD_DONE keeps READ asserted while the
    // RAM returns data, then captures it.
    // Reset abandons any in-flight access and gives no ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt <= '0;
`endif
        end else begin
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (dma_grant) begin
                        state <= dma_we ? DMA_WR : DMA_RD;
                    end
                end
                DMA_RD: begin
                    state <= DMA_RD_DONE;
                end
                DMA_RD_DONE: begin
                    dma_rdata <= mem_rdata;
                    dma_ack   <= 1'b1;
                    state     <= IDLE;
                end
                DMA_WR: begin
                    dma_ack <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef MEM_ARB_STARVE_GUARD_EN
            // Count only cycles in which the DMA actually lost to the CPU.
            // Saturate at the limit; any grant clears the count.
            if (dma_grant) begin
                starve_cnt <= '0;
            end else if ((state == IDLE) && dma_sample && cpu_active &&
                         (starve_cnt != STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A behavioural RAM answers the
// arbiter. The reference model works at the transaction level:
//   - a granted DMA access occupies the RAM for one cycle (write) or two
//     cycles (read);
//   - the ack follows in the next cycle;
//   - a model RAM array provides the expected read data.
// Directed steps cover the main scenarios, then a randomized phase runs.
// Honours MEM_ARB_STARVE_GUARD_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW         = 9;
    localparam int DW         = 16;
    localparam int STARVE_MAX = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    cpu_cmd;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram       [0:(1<<AW)-1];
    logic [DW-1:0] model_ram [0:(1<<AW)-1];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    int            busy;
    bit            busy_we;
    logic [AW-1:0] busy_addr;
    logic [DW-1:0] busy_wdata;
    bit            exp_ack;
    logic [DW-1:0] exp_rdata;
    int            starve;
    bit            cpu_rd_pending;
    logic [DW-1:0] cpu_rd_exp;
    logic [1:0]    exp_cmd;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    bit            exp_stall;
    bit            cpu_act;
    bit            req_seen;
    bit            grant;
    bit            forced;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data appears the cycle after READ.
    always @(posedge clk) begin
        if (mem_cmd == 2'b10) begin
            mem_rdata <= ram[mem_addr];
        end else if (mem_cmd == 2'b01) begin
            ram[mem_addr] = mem_wdata;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        busy           = 0;
        exp_ack        = 1'b0;
        exp_rdata      = '0;
        starve         = 0;
        cpu_rd_pending = 1'b0;
    endtask

    // Expected combinational outputs for the inputs currently applied.
    task automatic modelExpect();
        cpu_act   = (cpu_cmd == 2'b10) || (cpu_cmd == 2'b01);
        exp_cmd   = 2'b00;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_stall = 1'b0;
        grant     = 1'b0;
        forced    = 1'b0;
        req_seen  = 1'b0;
        if (busy > 0) begin
            exp_cmd   = busy_we ? 2'b01 : 2'b10;
            exp_addr  = busy_addr;
            exp_wdata = busy_wdata;
            exp_stall = cpu_act;
        end else begin
            req_seen = dma_req && !exp_ack;
            forced   = GUARD && req_seen && (starve >= STARVE_MAX);
            if (forced) begin
                exp_stall = cpu_act;
            end else if (cpu_act) begin
                exp_cmd   = cpu_cmd;
                exp_addr  = cpu_addr;
                exp_wdata = cpu_wdata;
            end
            grant = req_seen && (forced || !cpu_act);
        end
    endtask

    // Advance the model across one rising edge.
    task automatic modelAdvance();
        cpu_rd_pending = 1'b0;
        if (busy > 0) begin
            if (busy_we) model_ram[busy_addr] = busy_wdata;
            busy--;
            exp_ack = (busy == 0);
            if (busy == 0 && !busy_we) exp_rdata = model_ram[busy_addr];
        end else begin
            exp_ack = 1'b0;
            if (exp_cmd == 2'b10) begin
                cpu_rd_pending = 1'b1;
                cpu_rd_exp     = model_ram[exp_addr];
            end
            if (exp_cmd == 2'b01) model_ram[exp_addr] = exp_wdata;
            if (grant) begin
                busy       = dma_we ? 1 : 2;
                busy_we    = dma_we;
                busy_addr  = dma_addr;
                busy_wdata = dma_wdata;
                starve     = 0;
            end else if (GUARD && req_seen && cpu_act && starve < STARVE_MAX) begin
                starve++;
            end
        end
    endtask

    task automatic checkOutput();
        checkEq("mem_cmd", 32'(mem_cmd), 32'(exp_cmd));
        checkEq("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
        checkEq("dma_ack", 32'(dma_ack), 32'(exp_ack));
        checkEq("dma_rdata", 32'(dma_rdata), 32'(exp_rdata));
        if (exp_cmd != 2'b00) checkEq("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_cmd == 2'b01) checkEq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        if (cpu_rd_pending) checkEq("cpu_rd_data", 32'(mem_rdata), 32'(cpu_rd_exp));
    endtask

    // Drive one cycle of inputs at the falling edge, then check just after.
    task automatic applyStimulus(input logic [1:0] c_cmd, input logic [AW-1:0] c_addr,
                                 input logic [DW-1:0] c_wdata, input logic d_req,
                                 input logic d_we, input logic [AW-1:0] d_addr,
                                 input logic [DW-1:0] d_wdata);
        @(negedge clk);
        cpu_cmd   = c_cmd;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        dma_req   = d_req;
        dma_we    = d_we;
        dma_addr  = d_addr;
        dma_wdata = d_wdata;
        #1;
        modelExpect();
        checkOutput();
        modelAdvance();
    endtask

    initial begin
        int            cyc;
        int            stalls;
        int            acks;
        int            ack_at;
        bit            got;
        bit            req_on;
        logic          r_we;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_data;
        logic [1:0]    c_cmd;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_data;

        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]       = DW'(i * 16'h0101) ^ 16'h5A5A;
            model_ram[i] = ram[i];
        end
        ram[9'h010]       = 16'h1234;
        model_ram[9'h010] = 16'h1234;

        reset_n   = 1'b0;
        cpu_cmd   = 2'b00;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        modelReset();
        #1;
        $display("[TB] reset state");
        checkEq("rst_mem_cmd", 32'(mem_cmd), 32'h0);
        checkEq("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        checkEq("rst_dma_ack", 32'(dma_ack), 32'h0);
        checkEq("rst_dma_rdata", 32'(dma_rdata), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] CPU read passthrough");
        applyStimulus(2'b10, 9'h005, 16'h0, 1'b0, 1'b0, '0, '0);
        checkEq("cpu_rd_cmd", 32'(mem_cmd), 32'h2);
        checkEq("cpu_rd_addr", 32'(mem_addr), 32'h005);
        checkEq("cpu_rd_stall", 32'(cpu_stall), 32'h0);
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);

        $display("[TB] DMA write 0x1F0 (CPU cmd 11 = none)");
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            applyStimulus(2'b11, '0, '0, 1'b1, 1'b1, 9'h1F0, 16'hBEEF);
            cyc++;
            if (dma_ack) got = 1'b1;
        end
        checkEq("dma_wr_latency", 32'(cyc - 1), 32'd2);
        applyStimulus(2'b10, 9'h1F0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);
        checkEq("cpu_rd_after_dma_wr", 32'(mem_rdata), 32'hBEEF);

        $display("[TB] DMA read 0x010");
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 9'h010, '0);
            cyc++;
            if (dma_ack) got = 1'b1;
        end
        checkEq("dma_rd_latency", 32'(cyc - 1), 32'd3);
        checkEq("dma_rd_data", 32'(dma_rdata), 32'h1234);
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);

        $display("[TB] CPU read during DMA read");
        applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 9'h020, '0);
        stalls = 0;
        req_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b10, 9'h002, '0, req_on, 1'b0, 9'h020, '0);
            if (dma_ack) req_on = 1'b0;
            if (cpu_stall) stalls++;
            else break;
        end
        checkEq("cpu_stall_cycles", 32'(stalls), 32'd2);
        checkEq("cpu_fwd_cmd", 32'(mem_cmd), 32'h2);
        checkEq("cpu_fwd_addr", 32'(mem_addr), 32'h002);
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);

        $display("[TB] reset during DMA_RD_DONE");
        applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 9'h030, '0);
        applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 9'h030, '0);
        applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 9'h030, '0);
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkEq("rst_mid_mem_cmd", 32'(mem_cmd), 32'h0);
        checkEq("rst_mid_dma_ack", 32'(dma_ack), 32'h0);
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);
        checkEq("rst_mid_rdata", 32'(dma_rdata), 32'h0);

        $display("[TB] starvation under continuous CPU reads");
        acks   = 0;
        stalls = 0;
        ack_at = -1;
        req_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(2'b10, AW'($urandom_range(0, 63)), '0, req_on, 1'b0, 9'h040, '0);
            if (cpu_stall) stalls++;
            if (dma_ack) begin
                acks++;
                if (ack_at < 0) ack_at = i;
                req_on = 1'b0;
            end
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        checkEq("starve_acks", 32'(acks), 32'd1);
        checkEq("starve_ack_cycle", 32'(ack_at), 32'd11);
        checkEq("starve_stalls", 32'(stalls), 32'd3);
`else
        checkEq("starve_acks", 32'(acks), 32'd0);
        checkEq("starve_stalls", 32'(stalls), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 9'h040, '0);
            if (dma_ack) got = 1'b1;
        end
        checkEq("starve_drain_ack", 32'(got), 32'd1);
`endif
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);

        $display("[TB] randomized traffic");
        req_on = 1'b0;
        r_we   = 1'b0;
        r_addr = '0;
        r_data = '0;
        c_cmd  = 2'b00;
        c_addr = '0;
        c_data = '0;
        for (int i = 0; i < 600; i++) begin
            if (!req_on && $urandom_range(0, 3) == 0) begin
                req_on = 1'b1;
                r_we   = 1'($urandom_range(0, 1));
                r_addr = AW'($urandom_range(0, 63));
                r_data = DW'($urandom);
            end
            if (!cpu_stall) begin
                c_cmd  = 2'($urandom_range(0, 3));
                c_addr = AW'($urandom_range(0, 63));
                c_data = DW'($urandom);
            end
            applyStimulus(c_cmd, c_addr, c_data, req_on, r_we, r_addr, r_data);
            if (dma_ack) req_on = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
